// File: rtl/mul_div_unit.sv
// mul_div_unit: EX-stage multiply/divide unit that owns the architectural
// HI/LO pair. MULT/MULTU/DIV/DIVU run over a fixed latency. The result is
// computed at Start, held in pending registers, and committed when the
// latency counter expires. MTHI/MTLO and MFHI/MFLO are serviced here as well.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU
// (MulOp 1xx). When it is undefined, the 1xx codes are ignored and no
// accumulator adder exists.
module mul_div_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MulOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MTHILO,
  input  logic        MTHILOSel,
  input  logic [1:0]  MFHILO,
  output logic [31:0] Out,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Signed 32x32 -> 64 product (operands sign-extended to 64 bits first)
  function automatic logic [63:0] mul_signed(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = {{32{a[31]}}, a};
    bx = {{32{b[31]}}, b};
    return ax * bx;
  endfunction

  // Unsigned 32x32 -> 64 product
  function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = {32'd0, a};
    bx = {32'd0, b};
    return ax * bx;
  endfunction

  // Signed divide returning {remainder, quotient}. Divide-by-zero and the
  // INT_MIN / -1 overflow are resolved explicitly so that no simulator or
  // synthesis tool ever evaluates those cases natively.
  function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {r, q};
  endfunction

  // Unsigned divide returning {remainder, quotient}, with divide-by-zero resolved
  function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pend_q, pend_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic             valid_op_s;
  logic             idle_s;
  logic             launch_s;
  logic [63:0]      result_s;
  logic [CNT_W-1:0] load_s;

  // Decode MulOp: validity, latency and the 64-bit result to capture at Start
  always_comb begin
    valid_op_s = 1'b0;
    result_s   = 64'd0;
    load_s     = MUL_LOAD;
    case (MulOp)
      3'b000: begin
        valid_op_s = 1'b1;
        result_s   = mul_signed(A, B);
        load_s     = MUL_LOAD;
      end
      3'b001: begin
        valid_op_s = 1'b1;
        result_s   = mul_unsigned(A, B);
        load_s     = MUL_LOAD;
      end
      3'b010: begin
        valid_op_s = 1'b1;
        result_s   = div_signed(A, B);
        load_s     = DIV_LOAD;
      end
      3'b011: begin
        valid_op_s = 1'b1;
        result_s   = div_unsigned(A, B);
        load_s     = DIV_LOAD;
      end
`ifdef MDU_MADD_EN
      3'b100: begin
        valid_op_s = 1'b1;
        result_s   = {hi_q, lo_q} + mul_signed(A, B);
        load_s     = MUL_LOAD;
      end
      3'b101: begin
        valid_op_s = 1'b1;
        result_s   = {hi_q, lo_q} + mul_unsigned(A, B);
        load_s     = MUL_LOAD;
      end
      3'b110: begin
        valid_op_s = 1'b1;
        result_s   = {hi_q, lo_q} - mul_signed(A, B);
        load_s     = MUL_LOAD;
      end
      3'b111: begin
        valid_op_s = 1'b1;
        result_s   = {hi_q, lo_q} - mul_unsigned(A, B);
        load_s     = MUL_LOAD;
      end
`endif
      default: begin
        valid_op_s = 1'b0;
        result_s   = 64'd0;
        load_s     = MUL_LOAD;
      end
    endcase
  end

  // Launch/busy qualification; Busy must be visible in the Start cycle itself
  always_comb begin
    idle_s   = (cnt_q == CNT_ZERO);
    launch_s = Start && valid_op_s && idle_s;
    Busy     = launch_s || !idle_s;
  end

  // Next-state: launch wins over MTHILO; the countdown commits on its 1->0 step
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (launch_s) begin
      pend_d = result_s;
      cnt_d  = load_s;
    end else if (!idle_s) begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        hi_d = pend_q[63:32];
        lo_d = pend_q[31:0];
      end else begin
        hi_d = hi_q;
        lo_d = lo_q;
      end
    end else if (MTHILO) begin
      if (MTHILOSel) begin
        hi_d = A;
      end else begin
        lo_d = A;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset; reset drops any pending result
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= CNT_ZERO;
      pend_q <= 64'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  // MFHI/MFLO read mux; it shows the architectural values even while busy
  always_comb begin
    case (MFHILO)
      2'b01:   Out = hi_q;
      2'b10:   Out = lo_q;
      default: Out = 32'd0;
    endcase
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline; owns the HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency and services MTHI/MTLO/MFHI/MFLO.
- Drives the Busy signal that the hazard unit uses to stall ID when a HI/LO-touching instruction arrives while an operation is in flight.

Parameters:
- MUL_CYCLES, 5, cycles Busy stays high for MULT/MULTU, counting the Start cycle.
- DIV_CYCLES, 10, cycles Busy stays high for DIV/DIVU, counting the Start cycle.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle strobe: launch the operation selected by MulOp.
- MulOp  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 1xx reserved (see optional feature).
- A  input  32  operand rs (dividend).
- B  input  32  operand rt (divisor).
- MTHILO  input  1  write strobe for HI/LO from A.
- MTHILOSel  input  1  write target: 1 = HI, 0 = LO.
- MFHILO  input  2  read select: 00 none, 01 HI, 10 LO, 11 none.
- Out  output  32  read data for MFHI/MFLO.
- Busy  output  1  operation in flight.
- HI  output  32  architectural HI.
- LO  output  32  architectural LO.

Behaviour:
- Reset: HI=0, LO=0, counter=0, pending result=0. Busy=0 and Out=0 in the cycle after reset.
- Reset mid-operation discards the pending result. HI/LO are cleared and are not committed.
- Idle state (counter==0): Start with a valid MulOp captures the full 64-bit result into pending registers on that edge.
  - Counter loads MUL_CYCLES-1 or DIV_CYCLES-1.
- Busy = (Start && valid MulOp && idle) || (counter != 0). Busy is combinational, so the hazard unit sees it in the Start cycle.
- Counter decrements each cycle while nonzero. On the edge where it goes 1->0, HI/LO take the pending result and Busy falls.
- MULT: {HI,LO} = signed A*B, 64-bit. MULTU: the same product, unsigned.
- DIV: LO = quotient, HI = remainder, signed, truncating toward zero; the remainder takes the sign of the dividend.
- DIVU: the same, unsigned.
- Divide by zero (B==0): HI = A, LO = 32'hFFFF_FFFF. Full latency still applies.
- Signed overflow 0x80000000 / -1: LO = 0x80000000, HI = 0.
- Start while Busy: ignored; no restart and no counter change.
- MTHILO while idle: the selected register takes A on the next edge.
- MTHILO while Busy: ignored.
- MTHILO and Start in the same idle cycle: Start wins and MTHILO is dropped.
- Out is combinational: 01 gives HI, 10 gives LO, otherwise 0. While Busy, Out still shows the old HI/LO; the hazard unit prevents that case.
- MulOp 1xx with the macro undefined: treated as no-op. No Busy, no state change.

Optional Feature:
- Macro MDU_MADD_EN.
- When defined:
  - 100 MADD: {HI,LO} += signed A*B.
  - 101 MADDU: {HI,LO} += unsigned A*B.
  - 110 MSUB: {HI,LO} -= signed A*B.
  - 111 MSUBU: {HI,LO} -= unsigned A*B.
  - Latency is MUL_CYCLES.
  - The accumulate uses {HI,LO} sampled at Start. Arithmetic is 64-bit modulo 2^64.
- When undefined: 1xx codes are ignored as above, and no accumulator adder is synthesized.

Test Plan:
- Reset, then MULT A=32'hFFFF_FFFE (-2), B=3 -> Busy high for exactly 5 cycles from Start. After the fall, HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA.
- MULTU A=32'hFFFF_FFFF, B=2 -> HI=1, LO=32'hFFFF_FFFE after 5 cycles.
- DIV A=-7, B=2 -> Busy for 10 cycles, then LO=-3, HI=-1. DIVU A=7, B=0 -> HI=7, LO=32'hFFFF_FFFF.
- MTHILO=1, MTHILOSel=1, A=32'h1234 while idle -> HI=32'h1234 next cycle and Out=32'h1234 with MFHILO=01. Repeat while Busy -> HI unchanged.
- Start DIV, assert reset at cycle 4 -> Busy=0 and HI=LO=0 next cycle. No commit occurs at cycle 10.
- With MDU_MADD_EN: HI=0, LO=32'hFFFF_FFFF, then MADDU A=1, B=1 -> HI=1, LO=0. Without the macro, the same MulOp=101 gives Busy=0 and HI/LO unchanged.
